// File: rtl/oldest2_ring_tracker_pkg.sv
// Shared ring-tracker definitions: default ring geometry and the modular
// pointer arithmetic used by the head/tail pointers.
package oldest2_ring_tracker_pkg;

    localparam int unsigned SEL_WIDTH_DEF      = 16;
    localparam int unsigned PRIORITY_WIDTH_DEF = 4;

    // size must be a power of two; the caller narrows the result to its pointer width
    function automatic logic [31:0] ptr_add(input logic [31:0] ptr,
                                            input logic [31:0] inc,
                                            input logic [31:0] size);
        return (ptr + inc) & (size - 32'd1);
    endfunction

endpackage

// File: rtl/oldest2_ring_tracker.sv
// In-order ring of SEL_WIDTH entries feeding an oldest-2 arbiter: allocates up to
// two entries per cycle at the tail, tracks wake/issue, and retires up to two at the head.
module oldest2_ring_tracker
    import oldest2_ring_tracker_pkg::*;
#(
    parameter int unsigned SEL_WIDTH      = SEL_WIDTH_DEF,
    parameter int unsigned PRIORITY_WIDTH = PRIORITY_WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush_i,
    input  logic [1:0]                alloc_valid_i,
    output logic                      alloc_ready_o,
    output logic [PRIORITY_WIDTH-1:0] alloc_index0_o,
    output logic [PRIORITY_WIDTH-1:0] alloc_index1_o,
    input  logic                      wake_valid_i,
    input  logic [PRIORITY_WIDTH-1:0] wake_index_i,
    input  logic                      first_grant_valid_i,
    input  logic [PRIORITY_WIDTH-1:0] first_grant_index_i,
    input  logic                      second_grant_valid_i,
    input  logic [PRIORITY_WIDTH-1:0] second_grant_index_i,
    output logic [SEL_WIDTH-1:0]      req_o,
    output logic [PRIORITY_WIDTH-1:0] priority_fix_o,
    output logic [PRIORITY_WIDTH:0]   count_o
);

    localparam int unsigned PW = PRIORITY_WIDTH;
    localparam int unsigned CW = PRIORITY_WIDTH + 1;

    logic [SEL_WIDTH-1:0] valid_q, valid_d;
    logic [SEL_WIDTH-1:0] ready_q, ready_d;
    logic [SEL_WIDTH-1:0] issued_q, issued_d;
    logic [PW-1:0]        head_q, head_d, tail_q, tail_d;
    logic [PW-1:0]        head1, tail1;
    logic [CW-1:0]        count_q, count_d;
    logic                 acc0, acc1, ret0, ret1;
    logic [1:0]           n_alloc, n_ret;

    assign head1 = PW'(ptr_add(32'(head_q), 32'd1, 32'(SEL_WIDTH)));
    assign tail1 = PW'(ptr_add(32'(tail_q), 32'd1, 32'(SEL_WIDTH)));

    assign req_o          = valid_q & ready_q & ~issued_q;
    assign priority_fix_o = head_q;
    assign alloc_index0_o = tail_q;
    assign alloc_index1_o = tail1;
    assign count_o        = count_q;
    assign alloc_ready_o  = (count_q <= CW'(SEL_WIDTH - 2));

    // bit1 alone is an illegal request and is dropped rather than leaving a hole
    assign acc0    = alloc_ready_o & alloc_valid_i[0];
    assign acc1    = acc0 & alloc_valid_i[1];
    assign ret0    = valid_q[head_q] & issued_q[head_q];
    assign ret1    = ret0 & valid_q[head1] & issued_q[head1];
    assign n_alloc = {1'b0, acc0} + {1'b0, acc1};
    assign n_ret   = {1'b0, ret0} + {1'b0, ret1};

    always_comb begin
        valid_d  = valid_q;
        ready_d  = ready_q;
        issued_d = issued_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        if (flush_i) begin
            valid_d  = '0;
            ready_d  = '0;
            issued_d = '0;
            head_d   = '0;
            tail_d   = '0;
            count_d  = '0;
        end else begin
            if (wake_valid_i && valid_q[wake_index_i]) begin
                ready_d[wake_index_i] = 1'b1;
            end
            if (first_grant_valid_i && req_o[first_grant_index_i]) begin
                issued_d[first_grant_index_i] = 1'b1;
            end
            if (second_grant_valid_i && req_o[second_grant_index_i]) begin
                issued_d[second_grant_index_i] = 1'b1;
            end
            // retirement clears after wake so a late wake cannot resurrect a retired slot
            if (ret0) begin
                valid_d[head_q]  = 1'b0;
                ready_d[head_q]  = 1'b0;
                issued_d[head_q] = 1'b0;
            end
            if (ret1) begin
                valid_d[head1]  = 1'b0;
                ready_d[head1]  = 1'b0;
                issued_d[head1] = 1'b0;
            end
            if (acc0) begin
                valid_d[tail_q]  = 1'b1;
                ready_d[tail_q]  = 1'b0;
                issued_d[tail_q] = 1'b0;
            end
            if (acc1) begin
                valid_d[tail1]  = 1'b1;
                ready_d[tail1]  = 1'b0;
                issued_d[tail1] = 1'b0;
            end
            head_d  = PW'(ptr_add(32'(head_q), 32'(n_ret), 32'(SEL_WIDTH)));
            tail_d  = PW'(ptr_add(32'(tail_q), 32'(n_alloc), 32'(SEL_WIDTH)));
            count_d = count_q + CW'(n_alloc) - CW'(n_ret);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            ready_q  <= '0;
            issued_q <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            ready_q  <= ready_d;
            issued_q <= issued_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_oldest2_ring_tracker.sv
// Directed scoreboard bench for oldest2_ring_tracker: each stimulus cycle pushes
// its hand-computed post-edge outputs; a monitor pops and compares after every edge.
module tb_oldest2_ring_tracker;

    localparam int SW = 16;
    localparam int PW = 4;

    localparam logic [5:0] M_REQ = 6'd1;
    localparam logic [5:0] M_PF  = 6'd2;
    localparam logic [5:0] M_CNT = 6'd4;
    localparam logic [5:0] M_RDY = 6'd8;
    localparam logic [5:0] M_I0  = 6'd16;
    localparam logic [5:0] M_I1  = 6'd32;
    localparam logic [5:0] M_ALL = 6'd63;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush_i = 1'b0;
    logic [1:0]    alloc_valid_i = 2'b00;
    logic          alloc_ready_o;
    logic [PW-1:0] alloc_index0_o, alloc_index1_o;
    logic          wake_valid_i = 1'b0;
    logic [PW-1:0] wake_index_i = '0;
    logic          first_grant_valid_i = 1'b0;
    logic [PW-1:0] first_grant_index_i = '0;
    logic          second_grant_valid_i = 1'b0;
    logic [PW-1:0] second_grant_index_i = '0;
    logic [SW-1:0] req_o;
    logic [PW-1:0] priority_fix_o;
    logic [PW:0]   count_o;

    always #5 clk = ~clk;

    oldest2_ring_tracker #(.SEL_WIDTH(SW), .PRIORITY_WIDTH(PW)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .flush_i              (flush_i),
        .alloc_valid_i        (alloc_valid_i),
        .alloc_ready_o        (alloc_ready_o),
        .alloc_index0_o       (alloc_index0_o),
        .alloc_index1_o       (alloc_index1_o),
        .wake_valid_i         (wake_valid_i),
        .wake_index_i         (wake_index_i),
        .first_grant_valid_i  (first_grant_valid_i),
        .first_grant_index_i  (first_grant_index_i),
        .second_grant_valid_i (second_grant_valid_i),
        .second_grant_index_i (second_grant_index_i),
        .req_o                (req_o),
        .priority_fix_o       (priority_fix_o),
        .count_o              (count_o)
    );

    typedef struct {
        string      nm;
        logic [5:0] m;
        logic [15:0] req;
        logic [3:0] pf;
        logic [4:0] cnt;
        logic       rdy;
        logic [3:0] i0;
        logic [3:0] i1;
    } exp_t;

    exp_t sb[$];
    int nvec = 0;
    int nmis = 0;

    task automatic cmp(input string nm, input string f, input logic [31:0] act, input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nmis++;
            $display("FAIL %s.%s actual=%0h required=%0h", nm, f, act, req);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.m[0]) cmp(e.nm, "req_o",          32'(req_o),          32'(e.req));
            if (e.m[1]) cmp(e.nm, "priority_fix_o", 32'(priority_fix_o), 32'(e.pf));
            if (e.m[2]) cmp(e.nm, "count_o",        32'(count_o),        32'(e.cnt));
            if (e.m[3]) cmp(e.nm, "alloc_ready_o",  32'(alloc_ready_o),  32'(e.rdy));
            if (e.m[4]) cmp(e.nm, "alloc_index0_o", 32'(alloc_index0_o), 32'(e.i0));
            if (e.m[5]) cmp(e.nm, "alloc_index1_o", 32'(alloc_index1_o), 32'(e.i1));
        end
    end

    task automatic idle();
        flush_i              = 1'b0;
        alloc_valid_i        = 2'b00;
        wake_valid_i         = 1'b0;
        wake_index_i         = '0;
        first_grant_valid_i  = 1'b0;
        first_grant_index_i  = '0;
        second_grant_valid_i = 1'b0;
        second_grant_index_i = '0;
    endtask

    // push the outputs expected after the coming edge, then advance one cycle
    task automatic tick(input string nm, input logic [5:0] m, input logic [15:0] req,
                        input logic [3:0] pf, input logic [4:0] cnt, input logic rdy,
                        input logic [3:0] i0, input logic [3:0] i1);
        exp_t e;
        e.nm = nm; e.m = m; e.req = req; e.pf = pf; e.cnt = cnt;
        e.rdy = rdy; e.i0 = i0; e.i1 = i1;
        sb.push_back(e);
        @(negedge clk);
        idle();
    endtask

    task automatic wake(input logic [3:0] idx);
        wake_valid_i = 1'b1;
        wake_index_i = idx;
    endtask

    task automatic grant(input logic g0v, input logic [3:0] g0, input logic g1v, input logic [3:0] g1);
        first_grant_valid_i  = g0v;
        first_grant_index_i  = g0;
        second_grant_valid_i = g1v;
        second_grant_index_i = g1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        idle();
        @(negedge clk);
        tick("reset", M_ALL, 16'h0000, 0, 0, 1, 0, 1);
        rst_n = 1'b1;

        alloc_valid_i = 2'b11; tick("alloc1", M_ALL, 16'h0000, 0, 2, 1, 2, 3);
        alloc_valid_i = 2'b11; tick("alloc2", M_ALL, 16'h0000, 0, 4, 1, 4, 5);
        alloc_valid_i = 2'b11; tick("alloc3", M_ALL, 16'h0000, 0, 6, 1, 6, 7);
        alloc_valid_i = 2'b11; tick("alloc4", M_ALL, 16'h0000, 0, 8, 1, 8, 9);

        wake(0); tick("wake0", M_ALL, 16'h0001, 0, 8, 1, 8, 9);
        wake(1); tick("wake1", M_ALL, 16'h0003, 0, 8, 1, 8, 9);
        wake(3); tick("wake3", M_ALL, 16'h000B, 0, 8, 1, 8, 9);
        grant(1, 0, 1, 1); tick("grant01", M_ALL, 16'h0008, 0, 8, 1, 8, 9);
        tick("retire01", M_ALL, 16'h0008, 2, 6, 1, 8, 9);

        grant(1, 3, 0, 0); tick("ooo_grant3", M_REQ | M_PF | M_CNT, 16'h0000, 2, 6, 1, 0, 0);
        tick("ooo_hold", M_REQ | M_PF | M_CNT, 16'h0000, 2, 6, 1, 0, 0);
        wake(2); tick("wake2", M_REQ | M_PF | M_CNT, 16'h0004, 2, 6, 1, 0, 0);
        grant(1, 2, 1, 2); tick("grant2_dup", M_REQ | M_PF | M_CNT, 16'h0000, 2, 6, 1, 0, 0);
        tick("retire23", M_ALL, 16'h0000, 4, 4, 1, 8, 9);

        grant(0, 0, 1, 5); tick("grant_notready", M_REQ | M_CNT, 16'h0000, 4, 4, 1, 0, 0);
        wake(5); tick("wake5", M_REQ | M_PF, 16'h0020, 4, 4, 1, 0, 0);
        wake(9); tick("wake_invalid9", M_REQ | M_CNT, 16'h0020, 4, 4, 1, 0, 0);
        wake(4); tick("wake4", M_ALL, 16'h0030, 4, 4, 1, 8, 9);

        alloc_valid_i = 2'b11; wake(8);
        tick("fill1_wake8", M_ALL, 16'h0030, 4, 6, 1, 10, 11);
        alloc_valid_i = 2'b11; tick("fill2", M_ALL, 16'h0030, 4, 8, 1, 12, 13);
        alloc_valid_i = 2'b11; tick("fill3", M_ALL, 16'h0030, 4, 10, 1, 14, 15);
        alloc_valid_i = 2'b11; tick("fill4_wrap", M_ALL, 16'h0030, 4, 12, 1, 0, 1);
        alloc_valid_i = 2'b11; tick("fill5", M_ALL, 16'h0030, 4, 14, 1, 2, 3);
        alloc_valid_i = 2'b11; tick("fill6_full", M_ALL, 16'h0030, 4, 16, 0, 4, 5);
        alloc_valid_i = 2'b11; tick("full_ignore", M_ALL, 16'h0030, 4, 16, 0, 4, 5);
        grant(1, 4, 1, 5); tick("grant45", M_ALL, 16'h0000, 4, 16, 0, 4, 5);
        tick("retire45", M_ALL, 16'h0000, 6, 14, 1, 4, 5);
        alloc_valid_i = 2'b11; tick("refill16", M_ALL, 16'h0000, 6, 16, 0, 6, 7);

        wake(6); tick("wake6", M_REQ | M_CNT, 16'h0040, 6, 16, 0, 0, 0);
        grant(1, 6, 0, 0); tick("grant6", M_REQ | M_CNT, 16'h0000, 6, 16, 0, 0, 0);
        tick("count15", M_ALL, 16'h0000, 7, 15, 0, 6, 7);
        alloc_valid_i = 2'b01; tick("c15_alloc_ignored", M_ALL, 16'h0000, 7, 15, 0, 6, 7);

        wake(7); tick("wake7", M_REQ | M_CNT, 16'h0080, 7, 15, 0, 0, 0);
        flush_i = 1'b1; alloc_valid_i = 2'b01; wake(8); grant(1, 7, 0, 0);
        tick("flush", M_ALL, 16'h0000, 0, 0, 1, 0, 1);
        alloc_valid_i = 2'b11; tick("post_flush_a1", M_ALL, 16'h0000, 0, 2, 1, 2, 3);
        alloc_valid_i = 2'b11; tick("post_flush_a2", M_ALL, 16'h0000, 0, 4, 1, 4, 5);
        wake(1); tick("post_flush_wake1", M_ALL, 16'h0002, 0, 4, 1, 4, 5);

        #2;
        rst_n = 1'b0;
        alloc_valid_i = 2'b11; wake(2); grant(1, 1, 0, 0);
        tick("reset_midrun", M_ALL, 16'h0000, 0, 0, 1, 0, 1);
        rst_n = 1'b1;
        alloc_valid_i = 2'b11; tick("post_reset_alloc", M_ALL, 16'h0000, 0, 2, 1, 2, 3);

        repeat (2) @(posedge clk);
        #3;
        if (sb.size() != 0) begin
            nvec++;
            nmis++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
